// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader
//   Pop-side controller for a fifo_v2 queue. Pops BURST_LEN entries once the
//   almost-full watermark is seen. If entries sit below the watermark for
//   TIMEOUT cycles, it pops a single entry instead. Popped entries go out on a
//   registered valid/ready stream with a last marker.
// Ports
//   clk_i           clock, rising edge
//   rst_i           synchronous reset, active-high (priority over flush_i)
//   flush_i         synchronous abort, same effect as rst_i
//   fifo_empty_i    FIFO empty flag
//   fifo_alm_full_i FIFO fill >= watermark (watermark >= BURST_LEN)
//   fifo_data_i     FIFO head data
//   fifo_pop_o      pop FIFO head this cycle (combinational)
//   out_valid_o     stream beat valid
//   out_ready_i     sink accepts beat
//   out_data_o      stream data (registered)
//   out_last_o      final beat of the current burst
//   busy_o          high while a burst or single beat is in progress
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  fifo_empty_i,
  input  logic                  fifo_alm_full_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_pop_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_last_o,
  output logic                  busy_o
);

  localparam int MAX_CNT  = (BURST_LEN > TIMEOUT) ? BURST_LEN : TIMEOUT;
  localparam int CNT_W    = $clog2(MAX_CNT) + 1;
  // tmo counts the edges already seen with a non-empty FIFO. The switch to
  // SINGLE happens on the edge that brings tmo to TIMEOUT-1, so the forced
  // beat appears TIMEOUT cycles after the entry arrived.
  localparam int TMO_LAST = (TIMEOUT >= 2) ? (TIMEOUT - 2) : 0;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    SINGLE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] beats;
  logic [CNT_W-1:0] tmo;
  logic [CNT_W-1:0] target;
  logic             clear;
  logic             slot_free;

  assign clear      = rst_i | flush_i;
  assign slot_free  = !out_valid_o || out_ready_i;
  assign target     = (state == BURST) ? CNT_W'(BURST_LEN) : CNT_W'(1);
  assign busy_o     = (state != IDLE);
  assign fifo_pop_o = !clear && (state != IDLE) && !fifo_empty_i &&
                      slot_free && (beats < target);

  always_ff @(posedge clk_i) begin
    if (clear) begin
      state       <= IDLE;
      beats       <= '0;
      tmo         <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_last_o  <= 1'b0;
    end else begin
      if (fifo_pop_o) begin
        out_data_o  <= fifo_data_i;
        out_valid_o <= 1'b1;
        beats       <= beats + CNT_W'(1);
        out_last_o  <= (beats == target - CNT_W'(1));
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (fifo_alm_full_i) begin
            state <= BURST;
            tmo   <= '0;
          end else if (!fifo_empty_i) begin
            if (tmo >= CNT_W'(TMO_LAST)) begin
              state <= SINGLE;
              tmo   <= '0;
            end else begin
              tmo <= tmo + CNT_W'(1);
            end
          end else begin
            tmo <= '0;
          end
        end
        // Once the last beat has been popped, beats == target and no pop can
        // occur, so this never collides with the beat increment above.
        BURST, SINGLE: begin
          if (out_valid_o && out_ready_i && out_last_o) begin
            state <= IDLE;
            beats <= '0;
            tmo   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Testbench for fifo_burst_reader: FIFO model, scoreboard, vector table and
// hand-written timing sequences.
module tb_fifo_burst_reader;

  localparam int DW = 32;
  localparam int BL = 4;
  localparam int TO = 16;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          flush_i = 1'b0;
  logic          fifo_empty_i;
  logic          fifo_alm_full_i;
  logic [DW-1:0] fifo_data_i;
  logic          fifo_pop_o;
  logic          out_valid_o;
  logic          out_ready_i = 1'b1;
  logic [DW-1:0] out_data_o;
  logic          out_last_o;
  logic          busy_o;

  always #5 clk_i = ~clk_i;

  fifo_burst_reader #(
    .DATA_WIDTH(DW),
    .BURST_LEN (BL),
    .TIMEOUT   (TO)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .flush_i        (flush_i),
    .fifo_empty_i   (fifo_empty_i),
    .fifo_alm_full_i(fifo_alm_full_i),
    .fifo_data_i    (fifo_data_i),
    .fifo_pop_o     (fifo_pop_o),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_data_o     (out_data_o),
    .out_last_o     (out_last_o),
    .busy_o         (busy_o)
  );

  // FIFO model: watermark 4, af_ovr forces almost-full for short-fill bursts
  logic [DW-1:0] mem [64];
  logic [31:0]   wr = '0;
  logic [31:0]   rd = '0;
  logic          fifo_clr = 1'b0;
  logic          af_ovr = 1'b0;

  assign fifo_empty_i    = (wr == rd);
  assign fifo_alm_full_i = af_ovr || ((wr - rd) >= 32'd4);
  assign fifo_data_i     = mem[rd[5:0]];

  always @(posedge clk_i) begin
    if (fifo_clr)        rd <= wr;
    else if (fifo_pop_o) rd <= rd + 32'd1;
  end

  // Scoreboard
  logic [DW-1:0] exp_q [$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            beats_seen = 0;
  int            lasts_seen = 0;
  int            mdl_beat = 0;
  int            cur_target = BL;
  logic [31:0]   tag = 32'hD000_0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic sample();
    @(negedge clk_i);
    #1;
  endtask

  task automatic push();
    mem[wr[5:0]] = tag;
    exp_q.push_back(tag);
    wr  = wr + 32'd1;
    tag = tag + 32'd1;
  endtask

  task automatic do_reset();
    rst_i       = 1'b1;
    flush_i     = 1'b0;
    out_ready_i = 1'b1;
    af_ovr      = 1'b0;
    fifo_clr    = 1'b1;
    step();
    fifo_clr    = 1'b0;
    step();
    exp_q.delete();
    beats_seen  = 0;
    lasts_seen  = 0;
    mdl_beat    = 0;
    rst_i       = 1'b0;
  endtask

  // Monitor: a handshake seen at the negedge completes at the next posedge
  initial begin : monitor
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic [DW-1:0] ed;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk_i);
      if (rst_i || flush_i) begin
        prev_stall = 1'b0;
      end else begin
        if (fifo_pop_o) check("pop_while_empty", 32'(fifo_empty_i), 32'd0);
        if (prev_stall) begin
          check("stall_valid", 32'(out_valid_o), 32'd1);
          check("stall_data", out_data_o, prev_data);
          check("stall_last", 32'(out_last_o), 32'(prev_last));
        end
        if (out_valid_o && !out_ready_i) check("pop_while_stalled", 32'(fifo_pop_o), 32'd0);
        prev_stall = out_valid_o && !out_ready_i;
        prev_data  = out_data_o;
        prev_last  = out_last_o;
        if (out_valid_o && out_ready_i) begin
          beats_seen++;
          mdl_beat++;
          if (exp_q.size() == 0) begin
            check("extra_beat", 32'(exp_q.size()), 32'd1);
          end else begin
            ed = exp_q.pop_front();
            check("beat_data", out_data_o, ed);
          end
          check("beat_last", 32'(out_last_o), 32'(mdl_beat == cur_target));
          if (out_last_o) lasts_seen++;
          if (mdl_beat == cur_target) mdl_beat = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int n_push;
    int late_n;
    int late_at;
    bit pulse_af;
    int stall_beat;
    int stall_len;
    int target;
    int exp_beats;
    int budget;
  } vec_t;

  vec_t tbl [6];

  initial begin : stim
    int first_valid;
    int cyc;
    int stalled;
    bit done;
    logic exp_pop  [8];
    logic exp_busy [8];

    tbl[0] = '{n_push: 4, late_n: 0, late_at: -1, pulse_af: 0, stall_beat: -1, stall_len: 0, target: BL, exp_beats: 4, budget: 40};
    tbl[1] = '{n_push: 4, late_n: 0, late_at: -1, pulse_af: 0, stall_beat: 2,  stall_len: 3, target: BL, exp_beats: 4, budget: 40};
    tbl[2] = '{n_push: 2, late_n: 2, late_at: 5,  pulse_af: 1, stall_beat: -1, stall_len: 0, target: BL, exp_beats: 4, budget: 40};
    tbl[3] = '{n_push: 8, late_n: 0, late_at: -1, pulse_af: 0, stall_beat: 5,  stall_len: 2, target: BL, exp_beats: 8, budget: 60};
    tbl[4] = '{n_push: 1, late_n: 0, late_at: -1, pulse_af: 0, stall_beat: -1, stall_len: 0, target: 1,  exp_beats: 1, budget: 40};
    tbl[5] = '{n_push: 3, late_n: 0, late_at: -1, pulse_af: 0, stall_beat: -1, stall_len: 0, target: 1,  exp_beats: 3, budget: 100};

    // Reset with 5 entries queued: nothing moves during reset or just after
    rst_i = 1'b1;
    fifo_clr = 1'b1;
    step();
    fifo_clr = 1'b0;
    for (int i = 0; i < 5; i++) push();
    sample();
    check("rst_pop", 32'(fifo_pop_o), 32'd0);
    check("rst_valid", 32'(out_valid_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    step();
    rst_i = 1'b0;
    sample();
    check("post_rst_pop", 32'(fifo_pop_o), 32'd0);
    check("post_rst_valid", 32'(out_valid_o), 32'd0);
    check("post_rst_busy", 32'(busy_o), 32'd0);

    // Vector table
    for (int r = 0; r < 6; r++) begin
      do_reset();
      cur_target = tbl[r].target;
      for (int i = 0; i < tbl[r].n_push; i++) push();
      if (tbl[r].pulse_af) begin
        af_ovr = 1'b1;
        step();
        af_ovr = 1'b0;
      end
      cyc = 0;
      stalled = 0;
      done = 1'b0;
      while (!done) begin
        if (cyc == tbl[r].late_at)
          for (int i = 0; i < tbl[r].late_n; i++) push();
        if (beats_seen == tbl[r].stall_beat && stalled < tbl[r].stall_len) begin
          out_ready_i = 1'b0;
          stalled++;
        end else begin
          out_ready_i = 1'b1;
        end
        sample();
        if (beats_seen == tbl[r].exp_beats && !busy_o) done = 1'b1;
        else if (cyc >= tbl[r].budget) done = 1'b1;
        cyc++;
        step();
      end
      check($sformatf("v%0d_beats", r), 32'(beats_seen), 32'(tbl[r].exp_beats));
      check($sformatf("v%0d_lasts", r), 32'(lasts_seen), 32'(tbl[r].exp_beats / tbl[r].target));
      check($sformatf("v%0d_sb_left", r), 32'(exp_q.size()), 32'd0);
      check($sformatf("v%0d_fifo_empty", r), 32'(fifo_empty_i), 32'd1);
      check($sformatf("v%0d_busy", r), 32'(busy_o), 32'd0);
    end

    // Full-throughput burst: pop on four consecutive cycles, then idle
    exp_pop  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_busy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    cur_target = BL;
    for (int i = 0; i < 4; i++) push();
    for (int c = 0; c < 8; c++) begin
      sample();
      check($sformatf("thr_pop_c%0d", c), 32'(fifo_pop_o), 32'(exp_pop[c]));
      check($sformatf("thr_busy_c%0d", c), 32'(busy_o), 32'(exp_busy[c]));
      step();
    end
    check("thr_beats", 32'(beats_seen), 32'd4);

    // Timeout: single entry comes out TIMEOUT cycles after it arrives
    do_reset();
    cur_target = 1;
    push();
    first_valid = -1;
    for (int c = 0; c < 22; c++) begin
      sample();
      if (out_valid_o && first_valid < 0) first_valid = c;
      step();
    end
    check("tmo_first_valid_cycle", 32'(first_valid), 32'(TO));
    check("tmo_beats", 32'(beats_seen), 32'd1);
    check("tmo_lasts", 32'(lasts_seen), 32'd1);
    check("tmo_busy", 32'(busy_o), 32'd0);
    check("tmo_fifo_empty", 32'(fifo_empty_i), 32'd1);

    // Flush after two beats, then a fresh burst
    do_reset();
    cur_target = BL;
    for (int i = 0; i < 8; i++) push();
    cyc = 0;
    while (beats_seen < 2 && cyc < 20) begin
      sample();
      cyc++;
      if (beats_seen < 2) step();
    end
    check("fl_two_beats", 32'(beats_seen), 32'd2);
    step();
    flush_i = 1'b1;
    sample();
    check("fl_pop_during", 32'(fifo_pop_o), 32'd0);
    step();
    check("fl_valid", 32'(out_valid_o), 32'd0);
    check("fl_busy", 32'(busy_o), 32'd0);
    fifo_clr = 1'b1;
    step();
    fifo_clr = 1'b0;
    flush_i  = 1'b0;
    exp_q.delete();
    beats_seen = 0;
    lasts_seen = 0;
    mdl_beat   = 0;
    for (int i = 0; i < 4; i++) push();
    cyc = 0;
    done = 1'b0;
    while (!done) begin
      sample();
      if ((beats_seen == 4 && !busy_o) || cyc >= 30) done = 1'b1;
      cyc++;
      step();
    end
    check("fl_new_beats", 32'(beats_seen), 32'd4);
    check("fl_new_lasts", 32'(lasts_seen), 32'd1);
    check("fl_new_busy", 32'(busy_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
